// File: rtl/dds_cmd_loader.sv
// DDS command decoder: UART packet FSM, sample RAM loader,
// and phase accumulator driving the RAM read address.
module dds_cmd_loader #(
  parameter int unsigned ADDR_SZ = 8,
  parameter int unsigned DATA_SZ = 6,
  parameter int unsigned ACC_W = 32,
  parameter logic [ACC_W-1:0] FTW_RESET = 32'h0100_0000,
  parameter int unsigned TIMEOUT_CYCLES = 75000
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               rx_dv,
  input  logic [7:0]         rx_byte,
  output logic               ram_wr_en,
  output logic [ADDR_SZ-1:0] ram_wr_addr,
  output logic [DATA_SZ-1:0] ram_din,
  output logic [ADDR_SZ-1:0] ram_rd_addr,
  output logic               run,
  output logic               pkt_err,
  output logic [ADDR_SZ-1:0] wr_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned NB = ACC_W / 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_WLEN,
    S_WDATA,
    S_FTW,
    S_PHASE,
    S_RUNB
  } state_t;

  state_t             st;
  logic [TW-1:0]      tmo;
  logic [ADDR_SZ-1:0] len;
  logic [ADDR_SZ-1:0] wr_addr;
  logic [BW-1:0]      bidx;
  logic [ACC_W-9:0]   stage;
  logic [ACC_W-1:0]   ftw;
  logic [ACC_W-1:0]   acc;
  logic [ADDR_SZ-1:0] phase_off;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      tmo         <= '0;
      len         <= '0;
      wr_addr     <= '0;
      bidx        <= '0;
      stage       <= '0;
      ftw         <= FTW_RESET;
      acc         <= '0;
      phase_off   <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_din     <= '0;
      ram_rd_addr <= '0;
      run         <= 1'b0;
      pkt_err     <= 1'b0;
      wr_count    <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      pkt_err   <= 1'b0;
      if (run)
        acc <= acc + ftw;
      ram_rd_addr <= acc[ACC_W-1 -: ADDR_SZ] + phase_off;

      // Stalled packet: abandon it, keep whatever was already written.
      if (st != S_IDLE && !rx_dv && tmo == TMO_LAST) begin
        pkt_err <= 1'b1;
        st      <= S_IDLE;
        tmo     <= '0;
      end else begin
        if (rx_dv || st == S_IDLE)
          tmo <= '0;
        else
          tmo <= tmo + 1'b1;

        if (rx_dv) begin
          case (st)
            S_IDLE: begin
              if (rx_byte == 8'hA5)
                st <= S_OPC;
            end
            S_OPC: begin
              unique case (1'b1)
                (rx_byte == 8'h01): st <= S_WLEN;
                (rx_byte == 8'h02): begin
                  st   <= S_FTW;
                  bidx <= '0;
                end
                (rx_byte == 8'h03): st <= S_PHASE;
                (rx_byte == 8'h04): st <= S_RUNB;
                default: begin
                  pkt_err <= 1'b1;
                  st      <= S_IDLE;
                end
              endcase
            end
            S_WLEN: begin
              len     <= rx_byte[ADDR_SZ-1:0];
              wr_addr <= '0;
              st      <= S_WDATA;
            end
            S_WDATA: begin
              ram_wr_en   <= 1'b1;
              ram_din     <= rx_byte[7 -: DATA_SZ];
              ram_wr_addr <= wr_addr;
              wr_addr     <= wr_addr + 1'b1;
              // len of 0 wraps to all-ones here, i.e. 256 samples
              if (wr_addr == len - 1'b1) begin
                wr_count <= len;
                st       <= S_IDLE;
              end
            end
            S_FTW: begin
              stage <= {rx_byte, stage[ACC_W-9:8]};
              bidx  <= bidx + 1'b1;
              if (bidx == B_LAST) begin
                ftw <= {rx_byte, stage};
                st  <= S_IDLE;
              end
            end
            S_PHASE: begin
              phase_off <= rx_byte[ADDR_SZ-1:0];
              st        <= S_IDLE;
            end
            S_RUNB: begin
              run <= rx_byte[0];
              st  <= S_IDLE;
            end
            default: st <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_cmd_loader.sv
// Scoreboard bench for dds_cmd_loader: write and error events
// are queued at stimulus time and popped by negedge monitors.
module tb_dds_cmd_loader;

  localparam int TMO = 1000;

  logic       clk;
  logic       reset_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       ram_wr_en;
  logic [7:0] ram_wr_addr;
  logic [5:0] ram_din;
  logic [7:0] ram_rd_addr;
  logic       run;
  logic       pkt_err;
  logic [7:0] wr_count;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pend = 0;
  logic [13:0] wq[$];

  dds_cmd_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock_in(clk),
    .reset_n(reset_n),
    .rx_dv(rx_dv),
    .rx_byte(rx_byte),
    .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_din(ram_din),
    .ram_rd_addr(ram_rd_addr),
    .run(run),
    .pkt_err(pkt_err),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [5:0] d);
    wq.push_back({a, d});
  endtask

  // Write monitor
  always @(negedge clk) begin
    logic [13:0] e;
    if (ram_wr_en) begin
      if (wq.size() == 0) begin
        chk("wr_unexpected", {ram_wr_addr, ram_din}, 0);
        if ({ram_wr_addr, ram_din} == 14'd0) begin
          n_bad++;
          $display("FAIL wr_unexpected: write at addr 0 din 0");
        end
      end else begin
        e = wq.pop_front();
        chk("wr_addr", ram_wr_addr, e[13:6]);
        chk("wr_din", ram_din, e[5:0]);
      end
    end
  end

  // Error monitor
  always @(negedge clk) begin
    if (pkt_err) begin
      chk("pkt_err_expected", (err_pend > 0) ? 1 : 0, 1);
      if (err_pend > 0)
        err_pend--;
    end
  end

  initial begin
    logic [7:0] prev;
    logic [7:0] x;
    logic [7:0] ftw_bytes [5];
    int wrapped;
    reset_n = 1'b0;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    wait_n(3);
    reset_n = 1'b1;
    wait_n(1);

    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_wr_addr", ram_wr_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_run", run, 0);
    chk("rst_wr_count", wr_count, 0);
    wait_n(5);
    chk("idle_rd_addr", ram_rd_addr, 0);

    // Run with the reset tuning word: one address step per clock
    send_b(8'hA5); send_b(8'h04); send_b(8'h01);
    chk("run_on", run, 1);
    wait_n(2);
    wrapped = 0;
    for (int i = 0; i < 300; i++) begin
      prev = ram_rd_addr;
      @(negedge clk);
      if (prev == 8'hFF && ram_rd_addr == 8'h00)
        wrapped = 1;
      if (ram_rd_addr != 8'(prev + 1))
        chk("step1", ram_rd_addr, 8'(prev + 1));
      else
        n_cmp++;
    end
    chk("wrap", wrapped, 1);

    // Wave write of four samples
    exp_wr(8'd0, 6'h00);
    exp_wr(8'd1, 6'h10);
    exp_wr(8'd2, 6'h20);
    exp_wr(8'd3, 6'h3F);
    send_b(8'hA5); send_b(8'h01); send_b(8'h04);
    send_b(8'h00); send_b(8'h40); send_b(8'h80); send_b(8'hFC);
    wait_n(2);
    chk("wr_pending", wq.size(), 0);
    chk("wr_count4", wr_count, 4);

    // New tuning word; old word must hold until the packet completes
    ftw_bytes = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h80};
    for (int i = 0; i < 5; i++) begin
      prev = ram_rd_addr;
      send_b(ftw_bytes[i]);
      chk("ftw_no_partial", ram_rd_addr, 8'(prev + 1));
    end
    send_b(8'h00);
    wait_n(4);
    for (int i = 0; i < 20; i++) begin
      prev = ram_rd_addr;
      wait_n(2);
      chk("half_step", ram_rd_addr, 8'(prev + 1));
    end

    // Stop, then phase offsets against a held accumulator
    send_b(8'hA5); send_b(8'h04); send_b(8'h00);
    chk("run_off", run, 0);
    wait_n(3);
    x = ram_rd_addr;
    wait_n(5);
    chk("hold", ram_rd_addr, x);
    send_b(8'hA5); send_b(8'h03); send_b(8'h10);
    wait_n(2);
    chk("phase10", ram_rd_addr, 8'(x + 8'h10));
    send_b(8'hA5); send_b(8'h03); send_b(8'hF8);
    wait_n(2);
    chk("phaseF8", ram_rd_addr, 8'(x + 8'hF8));

    // Bad opcode, then a valid packet is accepted
    err_pend = 1;
    send_b(8'hA5); send_b(8'h07);
    wait_n(2);
    chk("badop_err", err_pend, 0);
    send_b(8'hA5); send_b(8'h04); send_b(8'h01);
    chk("after_badop_run", run, 1);

    // Timeout mid-payload
    exp_wr(8'd0, 6'h01);
    exp_wr(8'd1, 6'h02);
    exp_wr(8'd2, 6'h03);
    send_b(8'hA5); send_b(8'h01); send_b(8'h08);
    send_b(8'h04); send_b(8'h08); send_b(8'h0C);
    err_pend = 1;
    wait_n(TMO - 2);
    chk("tmo_not_early", err_pend, 1);
    wait_n(4);
    chk("tmo_err", err_pend, 0);
    chk("tmo_writes", wq.size(), 0);
    chk("tmo_wr_count", wr_count, 4);

    // Reset mid-payload
    exp_wr(8'd0, 6'h04);
    exp_wr(8'd1, 6'h05);
    send_b(8'hA5); send_b(8'h01); send_b(8'h08);
    send_b(8'h10); send_b(8'h14);
    wait_n(1);
    reset_n = 1'b0;
    #1;
    chk("arst_run", run, 0);
    chk("arst_wr_en", ram_wr_en, 0);
    chk("arst_rd_addr", ram_rd_addr, 0);
    chk("arst_wr_count", wr_count, 0);
    wait_n(2);
    reset_n = 1'b1;
    wait_n(1);
    send_b(8'h18); send_b(8'h1C);
    wait_n(3);
    chk("rst_writes", wq.size(), 0);
    chk("rst_run_low", run, 0);
    chk("rst_rd_hold", ram_rd_addr, 0);
    chk("err_left", err_pend, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
